// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite BRAM loader/reader shared types and constants
package sprite_pkg;

  localparam int HDR_BYTES    = 4;
  localparam int PIX_PER_BYTE = 8;
  localparam int ADR_W        = 16;
  localparam int DIM_W        = 10;
  localparam int AREA_W       = 2 * DIM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_DATA,
    ST_UNPACK,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } sprite_state_t;

endpackage

// File: rtl/sprite_byte_unpacker.sv
// rtl/sprite_byte_unpacker.sv - serialises one pixel byte MSB-first, one bit per step
module sprite_byte_unpacker
  import sprite_pkg::*;
(
  input  logic       clk_65mhz,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       step,
  input  logic       flush,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       bit_last
);

  localparam int CNT_W = $clog2(PIX_PER_BYTE);

  logic [7:0]       shift;
  logic [CNT_W-1:0] bit_cnt;

  assign bit_out  = shift[7];
  assign bit_last = bit_valid && (bit_cnt == CNT_W'(PIX_PER_BYTE - 1));

  always_ff @(posedge clk_65mhz) begin
    if (!reset_n) begin
      shift     <= 8'd0;
      bit_cnt   <= '0;
      bit_valid <= 1'b0;
    end else if (flush) begin
      bit_valid <= 1'b0;
    end else if (load) begin
      shift     <= load_byte;
      bit_cnt   <= '0;
      bit_valid <= 1'b1;
    end else if (step && bit_valid) begin
      shift   <= {shift[6:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_last) bit_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sprite_bram_writer.sv
// rtl/sprite_bram_writer.sv - byte stream to 1-bit sprite BRAM writer
// SPRITE_CHECKSUM_EN adds a trailing XOR checksum byte after the pixel data.
module sprite_bram_writer
  import sprite_pkg::*;
#(
  parameter int DEPTH   = 65536,
  parameter int MAX_DIM = 1023
) (
  input  logic             clk_65mhz,
  input  logic             reset_n,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             bram_we,
  output logic [ADR_W-1:0] bram_adr,
  output logic             bram_din,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [DIM_W-1:0] sprite_width,
  output logic [DIM_W-1:0] sprite_height
);

  localparam int SPAN_W = AREA_W + 1;

`ifdef SPRITE_CHECKSUM_EN
  localparam sprite_state_t PIX_END_STATE = ST_CSUM;
`else
  localparam sprite_state_t PIX_END_STATE = ST_DONE;
`endif

  sprite_state_t     state;
  logic [ADR_W-1:0]  base_q;
  logic [15:0]       width_q;
  logic [15:0]       height_q;
  logic [1:0]        hdr_cnt;
  logic [AREA_W-1:0] area_q;
  logic [AREA_W-1:0] pix_cnt;
  logic [AREA_W-1:0] pix_nxt;
  logic [AREA_W-1:0] area_calc;
  logic [SPAN_W-1:0] span;
  logic              dims_bad;
  logic              span_bad;
  logic              unp_bit;
  logic              unp_valid;
  logic              unp_last;
`ifdef SPRITE_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign sprite_width  = width_q[DIM_W-1:0];
  assign sprite_height = height_q[DIM_W-1:0];
  assign s_ready = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);

  // Product only meaningful when both dimensions pass the range check.
  assign area_calc = AREA_W'(width_q[DIM_W-1:0]) * AREA_W'(height_q[DIM_W-1:0]);
  assign span      = SPAN_W'(base_q) + SPAN_W'(area_calc);
  assign span_bad  = span > SPAN_W'(DEPTH);
  assign dims_bad  = (width_q == 16'd0) || (height_q == 16'd0) ||
                     (width_q > 16'(MAX_DIM)) || (height_q > 16'(MAX_DIM));
  assign pix_nxt   = pix_cnt + 1'b1;

  sprite_byte_unpacker u_unpacker (
    .clk_65mhz (clk_65mhz),
    .reset_n   (reset_n),
    .load      ((state == ST_DATA) && s_valid),
    .load_byte (s_data),
    .step      (state == ST_UNPACK),
    .flush     (state == ST_IDLE),
    .bit_out   (unp_bit),
    .bit_valid (unp_valid),
    .bit_last  (unp_last)
  );

  always_ff @(posedge clk_65mhz) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      width_q  <= 16'd0;
      height_q <= 16'd0;
      hdr_cnt  <= 2'd0;
      area_q   <= '0;
      pix_cnt  <= '0;
      bram_we  <= 1'b0;
      bram_adr <= '0;
      bram_din <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef SPRITE_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base_adr;
            width_q  <= 16'd0;
            height_q <= 16'd0;
            hdr_cnt  <= 2'd0;
            pix_cnt  <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
`ifdef SPRITE_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (s_valid) begin
            case (hdr_cnt)
              2'd0:    width_q[15:8]  <= s_data;
              2'd1:    width_q[7:0]   <= s_data;
              2'd2:    height_q[15:8] <= s_data;
              default: height_q[7:0]  <= s_data;
            endcase
`ifdef SPRITE_CHECKSUM_EN
            csum_q  <= csum_q ^ s_data;
`endif
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'(HDR_BYTES - 1)) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          area_q <= area_calc;
          state  <= (dims_bad || span_bad) ? ST_ERR : ST_DATA;
        end
        ST_DATA: begin
          if (s_valid) begin
`ifdef SPRITE_CHECKSUM_EN
            csum_q <= csum_q ^ s_data;
`endif
            state  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          if (unp_valid) begin
            bram_we  <= 1'b1;
            bram_adr <= base_q + pix_cnt[ADR_W-1:0];
            bram_din <= unp_bit;
            pix_cnt  <= pix_nxt;
            // Image end wins over byte end: the rest of the final byte is padding.
            if (pix_nxt == area_q) state <= PIX_END_STATE;
            else if (unp_last) state <= ST_DATA;
          end else begin
            state <= ST_DATA;
          end
        end
`ifdef SPRITE_CHECKSUM_EN
        ST_CSUM: begin
          if (s_valid) state <= (s_data == csum_q) ? ST_DONE : ST_ERR;
        end
`endif
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bram_writer.sv
// tb/tb_sprite_bram_writer.sv - scoreboard bench for sprite_bram_writer
// Define SPRITE_CHECKSUM_EN for both bench and RTL to cover the trailing checksum byte.
`timescale 1ns/1ps
module tb_sprite_bram_writer;

  logic        clk_65mhz = 1'b0;
  logic        reset_n, start, s_valid, s_ready;
  logic        bram_we, bram_din, busy, done, error;
  logic [15:0] base_adr, bram_adr;
  logic [7:0]  s_data;
  logic [9:0]  sprite_width, sprite_height;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int mon_acc = 0;
  int mon_pix_left = 0;
  int quiet = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  csum_acc;

  sprite_bram_writer dut (
    .clk_65mhz     (clk_65mhz),
    .reset_n       (reset_n),
    .start         (start),
    .base_adr      (base_adr),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .bram_we       (bram_we),
    .bram_adr      (bram_adr),
    .bram_din      (bram_din),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .sprite_width  (sprite_width),
    .sprite_height (sprite_height)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: pops expected writes, counts done pulses, polices s_ready during unpack.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk_65mhz);
      #1;
      if (done) done_cnt++;
      if (bram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got adr 0x%0h din %0b, want no write", bram_adr, bram_din);
        end else begin
          e = exp_q.pop_front();
          chk("bram_write", 32'({bram_adr, bram_din}), 32'(e));
        end
      end
      if (quiet > 0) begin
        chk("ready_in_unpack", 32'(s_ready), 0);
        quiet--;
      end else if (s_valid && s_ready) begin
        mon_acc++;
        if (mon_acc > 4 && mon_pix_left > 0) begin
          quiet = (mon_pix_left < 8) ? mon_pix_left : 8;
          mon_pix_left -= quiet;
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_ctl_zero"}, 32'({bram_we, bram_din, busy, done, error, s_ready}), 0);
    chk({name, "_adr_zero"}, 32'(bram_adr), 0);
    chk({name, "_dim_zero"}, 32'({sprite_width, sprite_height}), 0);
  endtask

  task automatic push_expect(input logic [15:0] base, input int area, input logic [15:0] px2);
    logic [7:0] b;
    for (int p = 0; p < area; p++) begin
      b = px2[15 - 8 * (p / 8) -: 8];
      exp_q.push_back({base + 16'(p), b[7 - (p % 8)]});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_65mhz);
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 300) begin
      @(negedge clk_65mhz);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready=0, want 1");
    end
    @(negedge clk_65mhz);
    s_valid  = 1'b0;
    csum_acc = csum_acc ^ b;
  endtask

  task automatic send_header(input logic [15:0] w, input logic [15:0] h, input bit gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
    send_byte(h[15:8], gaps);
    send_byte(h[7:0], gaps);
  endtask

  task automatic start_load(input logic [15:0] base, input int pix, input string name);
    @(negedge clk_65mhz);
    base_adr     = base;
    start        = 1'b1;
    csum_acc     = 8'd0;
    mon_acc      = 0;
    mon_pix_left = pix;
    quiet        = 0;
    @(negedge clk_65mhz);
    start = 1'b0;
    chk({name, "_busy_on_start"}, 32'(busy), 1);
    chk({name, "_error_cleared"}, 32'(error), 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk_65mhz);
      n++;
    end
    chk({name, "_busy_timeout"}, 32'(busy), 0);
    repeat (2) @(negedge clk_65mhz);
  endtask

  task automatic apply_reset(input string name, input int exp_left);
    reset_n = 1'b0;
    @(negedge clk_65mhz);
    #1;
    check_zero(name);
    chk({name, "_pending"}, exp_q.size(), exp_left);
    reset_n = 1'b1;
    exp_q.delete();
    quiet        = 0;
    mon_pix_left = 0;
  endtask

  // csum_byte < 0 sends the correct checksum (only used when the feature is built in).
  task automatic run_good(input logic [15:0] w, input logic [15:0] h, input logic [15:0] base,
                          input logic [15:0] px2, input int nbytes, input bit gaps,
                          input int csum_byte, input string name);
    int d0, e0, area;
    bit exp_bad;
    area = int'(w) * int'(h);
    push_expect(base, area, px2);
    d0 = done_cnt;
    e0 = wr_cnt;
    start_load(base, area, name);
    send_header(w, h, gaps);
    for (int i = 0; i < nbytes; i++) send_byte(px2[15 - 8 * i -: 8], gaps);
    exp_bad = (csum_byte >= 0) && (csum_byte != int'(csum_acc));
`ifdef SPRITE_CHECKSUM_EN
    send_byte((csum_byte >= 0) ? 8'(csum_byte) : csum_acc, gaps);
`endif
    wait_idle(name);
    chk({name, "_done_pulses"}, done_cnt - d0, exp_bad ? 0 : 1);
    chk({name, "_error"}, 32'(error), exp_bad ? 1 : 0);
    chk({name, "_write_count"}, wr_cnt - e0, area);
    chk({name, "_writes_left"}, exp_q.size(), 0);
    chk({name, "_width"}, 32'(sprite_width), 32'(w));
    chk({name, "_height"}, 32'(sprite_height), 32'(h));
  endtask

  task automatic run_bad_hdr(input logic [15:0] w, input logic [15:0] h, input logic [15:0] base,
                             input string name);
    int d0, e0;
    d0 = done_cnt;
    e0 = wr_cnt;
    start_load(base, 0, name);
    send_header(w, h, 1'b0);
    wait_idle(name);
    chk({name, "_error"}, 32'(error), 1);
    chk({name, "_no_writes"}, wr_cnt - e0, 0);
    chk({name, "_no_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    int n, e0;
    reset_n  = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'd0;
    base_adr = 16'd0;
    csum_acc = 8'd0;
    repeat (3) @(negedge clk_65mhz);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    run_good(16'd8, 16'd2, 16'd0, 16'hA53C, 2, 1'b0, -1, "img8x2");
    run_good(16'd3, 16'd3, 16'd100, 16'hFF80, 2, 1'b0, -1, "img3x3");
    run_bad_hdr(16'd0, 16'd2, 16'd0, "w_zero");
    run_good(16'd8, 16'd2, 16'd0, 16'hA53C, 2, 1'b1, -1, "gaps8x2");
    run_bad_hdr(16'd1024, 16'd1, 16'd0, "w_over");
    run_bad_hdr(16'd256, 16'd256, 16'd1, "span_over");

    // Exactly DEPTH pixels is legal: check the first byte lands, then abort.
    start_load(16'd0, 65536, "full");
    send_header(16'd256, 16'd256, 1'b0);
    push_expect(16'd0, 8, 16'hC300);
    send_byte(8'hC3, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_65mhz);
      n++;
    end
    #2;
    chk("full_writes_left", exp_q.size(), 0);
    chk("full_error", 32'(error), 0);
    chk("full_busy", 32'(busy), 1);
    chk("full_width", 32'(sprite_width), 256);
    chk("full_height", 32'(sprite_height), 256);
    apply_reset("full_abort", 0);

    start_load(16'd0, 16, "midrst");
    send_header(16'd8, 16'd2, 1'b0);
    push_expect(16'd0, 16, 16'hA53C);
    e0 = wr_cnt;
    send_byte(8'hA5, 1'b0);
    n = 0;
    while (wr_cnt - e0 < 5 && n < 40) begin
      @(negedge clk_65mhz);
      #2;
      n++;
    end
    chk("midrst_writes", wr_cnt - e0, 5);
    apply_reset("midrst", 11);

`ifdef SPRITE_CHECKSUM_EN
    run_good(16'd8, 16'd2, 16'd0, 16'hA53C, 2, 1'b0, 8'h94, "bad_csum");
`endif

    repeat (3) @(negedge clk_65mhz);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
